// File: rtl/keypad_scan_d.sv
// 4x4 matrix keypad reader.
// Drives one active-low column at a time and samples the active-low rows
// through a two-flop synchroniser. A press or release is accepted only after
// DEBOUNCE_CNT consecutive stable cycles. An accepted key produces a hex code
// with a one-cycle valid strobe. The last two accepted codes are kept on Y1
// (older) and Y0 (newer), ready for the 7-segment display scanner.
module keypad_scan_d #(
    parameter int SCAN_DIV     = 1024,
    parameter int DEBOUNCE_CNT = 100000
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic [3:0] Y0,
    output logic [3:0] Y1
);

    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t         state_r;
    logic [3:0]     sync1_r;
    logic [3:0]     sync2_r;
    logic [3:0]     row_s;
    logic [3:0]     pat_r;
    logic [1:0]     col_idx_r;
    logic [1:0]     col_next_s;
    logic [DW-1:0]  dwell_r;
    logic [DBW-1:0] deb_r;
    logic [3:0]     code_s;

    // True when exactly one row line is pulled low (a single, unambiguous key).
    function automatic logic single_zero(input logic [3:0] p);
        logic [3:0] z;
        z = ~p;
        return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
    endfunction

    // Index of the low row line; only meaningful when single_zero() holds.
    function automatic logic [1:0] zero_index(input logic [3:0] p);
        logic [1:0] idx;
        case (p)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Keypad legend: row r, column c -> hex code ('*' is E, '#' is F).
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'hE;
            4'b11_01: k = 4'h0;
            4'b11_10: k = 4'hF;
            4'b11_11: k = 4'hD;
            default:  k = 4'h0;
        endcase
        return k;
    endfunction

    // One-hot-low column drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = 4'b1110;
            2'd1:    d = 4'b1101;
            2'd2:    d = 4'b1011;
            2'd3:    d = 4'b0111;
            default: d = 4'b1110;
        endcase
        return d;
    endfunction

    assign row_s      = sync2_r;
    assign col_next_s = col_idx_r + 2'd1;
    assign code_s     = key_lookup(zero_index(pat_r), col_idx_r);

    // Two-flop synchroniser for the asynchronous row lines (idle high).
    always_ff @(posedge aclk) begin
        if (areset) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= row;
            sync2_r <= sync1_r;
        end
    end

    // Scan / debounce / held / release controller with registered outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r   <= ST_SCAN;
            col_idx_r <= 2'd0;
            col       <= 4'b1110;
            dwell_r   <= '0;
            deb_r     <= '0;
            pat_r     <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            Y0        <= 4'h0;
            Y1        <= 4'h0;
        end else begin
            key_valid <= 1'b0;
            case (state_r)
                ST_SCAN: begin
                    if (dwell_r == DWELL_LAST) begin
                        dwell_r <= '0;
                        if (row_s == 4'hF) begin
                            col_idx_r <= col_next_s;
                            col       <= col_drive(col_next_s);
                        end else begin
                            pat_r   <= row_s;
                            deb_r   <= '0;
                            state_r <= ST_DEBOUNCE;
                        end
                    end else begin
                        dwell_r <= dwell_r + DW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s != pat_r) begin
                        // Bounce or glitch: drop it and move on to the next column.
                        state_r   <= ST_SCAN;
                        dwell_r   <= '0;
                        col_idx_r <= col_next_s;
                        col       <= col_drive(col_next_s);
                    end else if (deb_r == DEB_LAST) begin
                        // Multi-key patterns are ambiguous: hold them off but emit nothing.
                        if (single_zero(pat_r)) begin
                            key_code  <= code_s;
                            Y1        <= Y0;
                            Y0        <= code_s;
                            key_valid <= 1'b1;
                        end else begin
                            key_valid <= 1'b0;
                        end
                        key_down <= 1'b1;
                        state_r  <= ST_HELD;
                    end else begin
                        deb_r <= deb_r + DBW'(1);
                    end
                end
                ST_HELD: begin
                    if (row_s == 4'hF) begin
                        deb_r   <= '0;
                        state_r <= ST_RELEASE;
                    end else begin
                        state_r <= ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (row_s != 4'hF) begin
                        state_r <= ST_HELD;
                    end else if (deb_r == DEB_LAST) begin
                        key_down  <= 1'b0;
                        state_r   <= ST_SCAN;
                        dwell_r   <= '0;
                        col_idx_r <= col_next_s;
                        col       <= col_drive(col_next_s);
                    end else begin
                        deb_r <= deb_r + DBW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_SCAN;
                    dwell_r   <= '0;
                    col_idx_r <= 2'd0;
                    col       <= 4'b1110;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_d.sv
// Self-checking bench for keypad_scan_d with SCAN_DIV=4, DEBOUNCE_CNT=8.
// The keypad itself is modelled physically: a 16-bit mask of pressed keys,
// and each row pin is pulled low when a pressed key sits on the column being
// driven low. Expected codes and Y1/Y0 history come from the key legend.
module tb_keypad_scan_d;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    localparam logic [3:0] KMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [3:0] Y0;
    logic [3:0] Y1;

    logic [15:0] press_mask = 16'h0000;

    int vectors = 0;
    int miscompares = 0;

    // Observed strobe history
    int         pulse_cnt = 0;
    int         b2b_cnt = 0;
    logic [3:0] last_code = 4'h0;
    logic       prev_valid = 1'b0;

    // Reference model state
    logic [3:0] exp_y0 = 4'h0;
    logic [3:0] exp_y1 = 4'h0;
    int         exp_pulses = 0;

    keypad_scan_d #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down),
        .Y0       (Y0),
        .Y1       (Y1)
    );

    always #5 aclk = ~aclk;

    function automatic logic [3:0] pins(input logic [15:0] m, input logic [3:0] c);
        logic [3:0] rv;
        rv = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (!c[ci] && m[ri*4+ci]) rv[ri] = 1'b0;
        return rv;
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        return 16'h0001 << (r * 4 + c);
    endfunction

    assign row = pins(press_mask, col);

    // Record every strobe and any strobe directly following another.
    always @(negedge aclk) begin
        if (key_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            last_code <= key_code;
            if (prev_valid) b2b_cnt <= b2b_cnt + 1;
        end
        prev_valid <= key_valid;
    end

    task automatic accept(input logic [3:0] code);
        exp_y1 = exp_y0;
        exp_y0 = code;
        exp_pulses++;
    endtask

    task automatic do_press(input logic [15:0] m, input int hold, input int rel,
                            output int np, output logic [3:0] code);
        int p0;
        p0 = pulse_cnt;
        press_mask = m;
        repeat (hold) @(negedge aclk);
        press_mask = 16'h0000;
        repeat (rel) @(negedge aclk);
        np = pulse_cnt - p0;
        code = last_code;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        press_mask = 16'h0000;
        repeat (3) @(negedge aclk);
        vectors++; if (col !== 4'b1110) begin miscompares++; $display("FAIL reset_col: got %b expected 1110", col); end
        vectors++; if (key_code !== 4'h0) begin miscompares++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
        vectors++; if (Y0 !== 4'h0 || Y1 !== 4'h0) begin miscompares++; $display("FAIL reset_y: got Y1=%h Y0=%h expected 0 0", Y1, Y0); end
    endtask

    task automatic test_scan_rotation();
        logic [3:0] e;
        areset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge aclk);
            e = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            vectors++; if (col !== e) begin miscompares++; $display("FAIL scan_col[%0d]: got %b expected %b", k, col, e); end
            vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL scan_valid[%0d]: got %b expected 0", k, key_valid); end
        end
        vectors++; if (Y0 !== 4'h0 || Y1 !== 4'h0) begin miscompares++; $display("FAIL scan_y: got Y1=%h Y0=%h expected 0 0", Y1, Y0); end
    endtask

    // Key "1" held through reset release: col0 is already driven, so the
    // strobe lands after 2 sync + 2 dwell + 8 debounce edges = edge 12.
    task automatic test_min_latency();
        logic [3:0] e;
        areset = 1'b1;
        press_mask = key_bit(0, 0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        exp_y0 = 4'h0;
        exp_y1 = 4'h0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge aclk);
            vectors++; if (key_valid !== (k == 12)) begin miscompares++; $display("FAIL latency_valid[%0d]: got %b expected %b", k, key_valid, (k == 12)); end
            vectors++; if (key_down !== (k >= 12)) begin miscompares++; $display("FAIL latency_down[%0d]: got %b expected %b", k, key_down, (k >= 12)); end
            if (k == 12) begin
                vectors++; if (key_code !== 4'h1) begin miscompares++; $display("FAIL latency_code: got %h expected 1", key_code); end
            end
        end
        accept(4'h1);
        // Release: row_s idle after 2 edges, HELD->RELEASE next, then 8 release cycles.
        press_mask = 16'h0000;
        for (int j = 1; j <= 12; j++) begin
            @(negedge aclk);
            e = (j >= 11) ? 4'b1101 : 4'b1110;
            vectors++; if (key_down !== (j <= 10)) begin miscompares++; $display("FAIL release_down[%0d]: got %b expected %b", j, key_down, (j <= 10)); end
            vectors++; if (col !== e) begin miscompares++; $display("FAIL release_col[%0d]: got %b expected %b", j, col, e); end
        end
        vectors++; if (Y0 !== exp_y0 || Y1 !== exp_y1) begin miscompares++; $display("FAIL latency_y: got Y1=%h Y0=%h expected %h %h", Y1, Y0, exp_y1, exp_y0); end
    endtask

    task automatic test_key6();
        int p0;
        p0 = pulse_cnt;
        press_mask = key_bit(1, 2);
        repeat (40) @(negedge aclk);
        vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL key6_down_held: got %b expected 1", key_down); end
        press_mask = 16'h0000;
        repeat (20) @(negedge aclk);
        accept(KMAP[1][2]);
        vectors++; if (pulse_cnt - p0 !== 1) begin miscompares++; $display("FAIL key6_pulses: got %0d expected 1", pulse_cnt - p0); end
        vectors++; if (key_code !== 4'h6) begin miscompares++; $display("FAIL key6_code: got %h expected 6", key_code); end
        vectors++; if (Y0 !== exp_y0 || Y1 !== exp_y1) begin miscompares++; $display("FAIL key6_y: got Y1=%h Y0=%h expected %h %h", Y1, Y0, exp_y1, exp_y0); end
        vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL key6_down_released: got %b expected 0", key_down); end
    endtask

    task automatic test_two_keys();
        int np1, np2;
        logic [3:0] c1, c2;
        do_press(key_bit(0, 2), 40, 20, np1, c1);
        accept(KMAP[0][2]);
        do_press(key_bit(2, 3), 40, 20, np2, c2);
        accept(KMAP[2][3]);
        vectors++; if (np1 + np2 !== 2) begin miscompares++; $display("FAIL two_pulses: got %0d expected 2", np1 + np2); end
        vectors++; if (c1 !== 4'h3) begin miscompares++; $display("FAIL two_code1: got %h expected 3", c1); end
        vectors++; if (Y1 !== 4'h3 || Y0 !== 4'hC) begin miscompares++; $display("FAIL two_y: got Y1=%h Y0=%h expected 3 c", Y1, Y0); end
    endtask

    task automatic test_bounce();
        int p0, np;
        logic [3:0] c;
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            press_mask = (i % 2 == 0) ? key_bit(0, 0) : 16'h0000;
            repeat (3) @(negedge aclk);
        end
        vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL bounce_quiet: got %0d pulses expected 0", pulse_cnt - p0); end
        do_press(key_bit(0, 0), 40, 20, np, c);
        accept(KMAP[0][0]);
        vectors++; if (np !== 1) begin miscompares++; $display("FAIL bounce_pulses: got %0d expected 1", np); end
        vectors++; if (c !== 4'h1) begin miscompares++; $display("FAIL bounce_code: got %h expected 1", c); end
        vectors++; if (Y0 !== exp_y0 || Y1 !== exp_y1) begin miscompares++; $display("FAIL bounce_y: got Y1=%h Y0=%h expected %h %h", Y1, Y0, exp_y1, exp_y0); end
    endtask

    task automatic test_ghost();
        int p0;
        bit found;
        p0 = pulse_cnt;
        press_mask = key_bit(0, 1) | key_bit(1, 1);
        repeat (40) @(negedge aclk);
        vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL ghost_down: got %b expected 1", key_down); end
        press_mask = 16'h0000;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge aclk);
            if (key_down === 1'b0) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL ghost_release_timeout: got key_down=%b expected 0 within 40 cycles", key_down); end
        vectors++; if (col !== 4'b1011) begin miscompares++; $display("FAIL ghost_resume_col: got %b expected 1011", col); end
        repeat (10) @(negedge aclk);
        vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL ghost_pulses: got %0d expected 0", pulse_cnt - p0); end
        vectors++; if (Y0 !== exp_y0 || Y1 !== exp_y1) begin miscompares++; $display("FAIL ghost_y: got Y1=%h Y0=%h expected %h %h", Y1, Y0, exp_y1, exp_y0); end
    endtask

    task automatic test_random();
        int r, c, gr, gc, glen, p0, np;
        logic [3:0] code;
        for (int it = 0; it < 12; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            gr = $urandom_range(0, 3);
            gc = $urandom_range(0, 3);
            glen = $urandom_range(1, DEBOUNCE_CNT);
            p0 = pulse_cnt;
            // A press no longer than the debounce window can never be accepted.
            press_mask = key_bit(gr, gc);
            repeat (glen) @(negedge aclk);
            press_mask = 16'h0000;
            repeat (20) @(negedge aclk);
            do_press(key_bit(r, c), 40 + $urandom_range(0, 20), 20 + $urandom_range(0, 10), np, code);
            accept(KMAP[r][c]);
            vectors++; if (pulse_cnt - p0 !== 1) begin miscompares++; $display("FAIL rand_pulses[%0d]: got %0d expected 1 (glitch len %0d)", it, pulse_cnt - p0, glen); end
            vectors++; if (code !== KMAP[r][c]) begin miscompares++; $display("FAIL rand_code[%0d]: got %h expected %h (r%0d c%0d)", it, code, KMAP[r][c], r, c); end
            vectors++; if (Y0 !== exp_y0 || Y1 !== exp_y1) begin miscompares++; $display("FAIL rand_y[%0d]: got Y1=%h Y0=%h expected %h %h", it, Y1, Y0, exp_y1, exp_y0); end
            vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL rand_down[%0d]: got %b expected 0", it, key_down); end
        end
    endtask

    task automatic test_reset_mid();
        int p0, np;
        bit found;
        logic [3:0] code;
        // Align to col0, press "5", wait for col1, then reset mid-debounce.
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge aclk);
            if (col === 4'b1110) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL mid_align0_timeout: got col=%b expected 1110", col); end
        press_mask = key_bit(1, 1);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge aclk);
            if (col === 4'b1101) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL mid_align1_timeout: got col=%b expected 1101", col); end
        repeat (6) @(negedge aclk);
        p0 = pulse_cnt;
        areset = 1'b1;
        press_mask = 16'h0000;
        @(negedge aclk);
        areset = 1'b0;
        exp_y0 = 4'h0;
        exp_y1 = 4'h0;
        vectors++; if (col !== 4'b1110) begin miscompares++; $display("FAIL mid_deb_col: got %b expected 1110", col); end
        vectors++; if (key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin miscompares++; $display("FAIL mid_deb_outs: got code=%h valid=%b down=%b expected 0 0 0", key_code, key_valid, key_down); end
        vectors++; if (Y0 !== 4'h0 || Y1 !== 4'h0) begin miscompares++; $display("FAIL mid_deb_y: got Y1=%h Y0=%h expected 0 0", Y1, Y0); end
        repeat (20) @(negedge aclk);
        vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL mid_deb_pulses: got %0d expected 0", pulse_cnt - p0); end
        // Reset while a key is held.
        p0 = pulse_cnt;
        press_mask = key_bit(2, 1);
        repeat (40) @(negedge aclk);
        accept(KMAP[2][1]);
        vectors++; if (key_down !== 1'b1 || pulse_cnt - p0 !== 1) begin miscompares++; $display("FAIL mid_held_setup: got down=%b pulses=%0d expected 1 1", key_down, pulse_cnt - p0); end
        areset = 1'b1;
        press_mask = 16'h0000;
        @(negedge aclk);
        areset = 1'b0;
        exp_y0 = 4'h0;
        exp_y1 = 4'h0;
        vectors++; if (col !== 4'b1110 || key_down !== 1'b0 || key_valid !== 1'b0) begin miscompares++; $display("FAIL mid_held_outs: got col=%b down=%b valid=%b expected 1110 0 0", col, key_down, key_valid); end
        vectors++; if (Y0 !== 4'h0 || Y1 !== 4'h0 || key_code !== 4'h0) begin miscompares++; $display("FAIL mid_held_y: got Y1=%h Y0=%h code=%h expected 0 0 0", Y1, Y0, key_code); end
        repeat (20) @(negedge aclk);
        do_press(key_bit(3, 1), 40, 20, np, code);
        accept(KMAP[3][1]);
        vectors++; if (np !== 1) begin miscompares++; $display("FAIL after_reset_pulses: got %0d expected 1", np); end
        vectors++; if (key_code !== 4'h0 || code !== 4'h0) begin miscompares++; $display("FAIL after_reset_code: got %h expected 0", key_code); end
        vectors++; if (Y0 !== exp_y0 || Y1 !== exp_y1) begin miscompares++; $display("FAIL after_reset_y: got Y1=%h Y0=%h expected %h %h", Y1, Y0, exp_y1, exp_y0); end
    endtask

    task automatic test_back_to_back();
        vectors++; if (b2b_cnt !== 0) begin miscompares++; $display("FAIL back_to_back: got %0d adjacent strobes expected 0", b2b_cnt); end
        vectors++; if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL total_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_scan_rotation();
        test_min_latency();
        test_key6();
        test_two_keys();
        test_bounce();
        test_ghost();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before 40000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scan_d.md
Name: keypad_scan_d

Overview:
- 4x4 matrix keypad reader; the input-side counterpart of the 7-segment display scanner.
- Drives one active-low column at a time and samples the four active-low row lines.
- Debounces press and release, then emits a 4-bit hex key code with a one-cycle valid strobe.
- Keeps the last two keys as Y1 (older) and Y0 (newer), so they feed the display scanner's Y1/Y0 inputs directly.

Parameters:
- SCAN_DIV, 1024, clock cycles each column is driven before its rows are evaluated (min 4).
- DEBOUNCE_CNT, 100000, consecutive stable cycles required to accept a press or a release (min 2).

Ports:
- aclk  input  1  system clock.
- areset  input  1  synchronous reset, active-high.
- row  input  4  keypad row lines, active-low, externally pulled up, asynchronous.
- col  output  4  keypad column drive, active-low, one-hot-low.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when key_code updates.
- key_down  output  1  high while the accepted key is held, until release is debounced.
- Y0  output  4  newest accepted key code.
- Y1  output  4  previous accepted key code.

Behaviour:
- Reset values, applied on any aclk edge with areset=1, including mid-debounce:
  - state=SCAN, col=4'b1110, key_code=0, key_valid=0, key_down=0, Y0=0, Y1=0.
  - All counters are 0 and the synchroniser flops are 4'b1111.
- row passes through a 2-flop synchroniser to give row_s; all decisions use row_s.
- SCAN state:
  - dwell counter counts 0..SCAN_DIV-1 on the current column.
  - At SCAN_DIV-1, if row_s==4'b1111, the active column rotates 0->1->2->3->0 (col 1110->1101->1011->0111->1110) and dwell resets.
  - Otherwise, save row_s as pat, clear deb, go to DEBOUNCE. col holds.
- DEBOUNCE state:
  - Each cycle with row_s==pat, deb increments.
  - If row_s!=pat on any cycle, go to SCAN, advance the column, reset dwell. Nothing is emitted.
  - When deb reaches DEBOUNCE_CNT-1 with a match:
    - If pat has exactly one zero bit: key_code<=code, Y1<=Y0, Y0<=code, key_valid=1 for exactly that one cycle, key_down<=1, go to HELD.
    - If pat has multiple zero bits (ghosting/multi-press): emit nothing, key_down<=1, go to HELD.
- Key map (row r = zero bit of pat, c = active column):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- HELD state:
  - col holds.
  - When row_s==4'b1111, clear deb and go to RELEASE.
  - Additional presses on the same column are ignored.
- RELEASE state:
  - Each cycle with row_s==4'b1111, deb increments.
  - Any row low returns to HELD with no emission.
  - At DEBOUNCE_CNT-1: key_down<=0, go to SCAN, advance the column, reset dwell.
- Width rules: dwell uses $clog2(SCAN_DIV) bits and deb uses $clog2(DEBOUNCE_CNT) bits. Both saturate/reset explicitly and never wrap mid-state.
- Latency, from row change at the pin to key_valid, on the column being driven:
  - 2 sync cycles + remaining dwell + DEBOUNCE_CNT cycles.
  - Minimum press-to-valid with the column already active and dwell at SCAN_DIV-1: 2+1+(DEBOUNCE_CNT-1)+1.
- Simultaneous events: key_valid is never asserted in back-to-back cycles. A new key is never accepted until the release of the previous one is debounced.
- Outputs are registered. key_code, Y0, Y1 hold their values between presses.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
1. Reset, no keys for 64 cycles -> col cycles 1110,1101,1011,0111 with 4 cycles each; key_valid stays 0; Y0=Y1=0.
2. Hold row=1101 while col=1011 (row1, col2) for 40 cycles, then release for 20 -> exactly one key_valid pulse with key_code=6; Y0=6, Y1=0; key_down high until 8 cycles after row_s returns to 1111.
3. Press "3", release, then press "C" -> Y1=3, Y0=C after the second pulse; exactly two key_valid pulses total.
4. Bounce: toggle row bit0 every 3 cycles on col0 for 30 cycles, then hold low for 20 -> no pulse during bouncing; one pulse with key_code=1 after the stable hold.
5. Ghost: row=1100 (rows 0 and 1 both low) on col1 for 20 cycles -> no key_valid, key_down=1; after release, scanning resumes from col2.
6. Assert areset for 1 cycle mid-DEBOUNCE and mid-HELD -> next cycle all outputs are at reset values, col=1110; a subsequent clean press of "0" yields key_code=0 with one pulse.
